// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for two register-file writers, with a pending-write scoreboard.
// Optional: define GPR_WB_ARB_FIXED_PRIO_EN to make requester A always win contention.
module gpr_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_num,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_num,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_num,
  output logic              reg_write,
  output logic [ADDR_W-1:0] num_write,
  output logic [DATA_W-1:0] data_write,
  output logic [31:0]       pending
);

  localparam int NREG = 32;

  logic              grant_a;
  logic              grant_b;
  logic              xfer_p0;
  logic [ADDR_W-1:0] num_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] num_p1;
  logic [DATA_W-1:0] data_p1;
  logic [NREG-1:0]   pending_p1;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;

  function automatic logic [NREG-1:0] reg_bit(input logic [ADDR_W-1:0] n);
    reg_bit = {{(NREG-1){1'b0}}, 1'b1} << n;
  endfunction

`ifdef GPR_WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = a_valid;
      grant_b = b_valid & ~a_valid;
    end
  end
`else
  // last_b = 1 means B was granted most recently, so A wins the next contention
  logic last_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = a_valid & (~b_valid | last_b);
      grant_b = b_valid & ~grant_a;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      last_b <= 1'b1;
    else if (grant_a | grant_b)
      last_b <= grant_b;
  end
`endif

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer_p0 = grant_a | grant_b;
  assign num_p0  = grant_a ? a_num  : b_num;
  assign data_p0 = grant_a ? a_data : b_data;

  // p0 -> p1: capture the accepted write; register 0 writes are swallowed
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      num_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0 && (num_p0 != '0);
      if (xfer_p0 && (num_p0 != '0)) begin
        num_p1  <= num_p0;
        data_p1 <= data_p0;
      end
    end
  end

  // A write clears its bit on the edge it commits; a same-cycle issue re-sets it
  assign set_mask = (issue_valid && (issue_num != '0)) ? reg_bit(issue_num) : '0;
  assign clr_mask = vld_p1 ? reg_bit(num_p1) : '0;

  always_ff @(posedge clock) begin
    if (reset)
      pending_p1 <= '0;
    else
      pending_p1 <= ((pending_p1 & ~clr_mask) | set_mask) & ~{{(NREG-1){1'b0}}, 1'b1};
  end

  assign reg_write  = vld_p1;
  assign num_write  = num_p1;
  assign data_write = data_p1;
  assign pending    = pending_p1;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_gpr_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              a_valid, b_valid, issue_valid;
  logic [ADDR_W-1:0] a_num, b_num, issue_num;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready, reg_write;
  logic [ADDR_W-1:0] num_write;
  logic [DATA_W-1:0] data_write;
  logic [31:0]       pending;

  gpr_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_num(a_num), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_num(b_num), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_num(issue_num),
    .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
    .pending(pending)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: who won last, the set of outstanding registers, the write seen next cycle
  string             m_last_winner;
  bit [31:0]         m_pend;
  bit                m_wr;
  logic [ADDR_W-1:0] m_num;
  logic [DATA_W-1:0] m_data;
  bit                ga, gb;
  logic              obs_a, obs_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit av, input logic [ADDR_W-1:0] an, input logic [DATA_W-1:0] ad,
                       input bit bv, input logic [ADDR_W-1:0] bn, input logic [DATA_W-1:0] bd,
                       input bit iv, input logic [ADDR_W-1:0] inum);
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] wd;
    reset = r; a_valid = av; a_num = an; a_data = ad;
    b_valid = bv; b_num = bn; b_data = bd; issue_valid = iv; issue_num = inum;
    #2;
    ga = 0; gb = 0;
    if (!r) begin
      if (av && bv) begin
`ifdef GPR_WB_ARB_FIXED_PRIO_EN
        ga = 1;
`else
        if (m_last_winner == "B") ga = 1; else gb = 1;
`endif
      end else begin
        ga = av; gb = bv;
      end
    end
    obs_a = a_ready; obs_b = b_ready;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    @(posedge clock);
    if (r) begin
      m_pend = 0; m_wr = 0; m_num = 0; m_data = 0; m_last_winner = "B";
    end else begin
      if (m_wr) m_pend[m_num] = 1'b0;
      if (iv && inum != 0) m_pend[inum] = 1'b1;
      m_wr = 0;
      if (ga || gb) begin
        wn = ga ? an : bn;
        wd = ga ? ad : bd;
        m_last_winner = ga ? "A" : "B";
        if (wn != 0) begin m_wr = 1; m_num = wn; m_data = wd; end
      end
    end
    #1;
    chk("reg_write", reg_write, m_wr);
    chk("num_write", num_write, m_num);
    chk("data_write", data_write, m_data);
    chk("pending", pending, m_pend);
  endtask

  task automatic idle(input bit r);
    cycle(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit                hav, hbv, hiv, rr;
  logic [ADDR_W-1:0] han, hbn, hin;
  logic [DATA_W-1:0] had, hbd;

  initial begin
    m_last_winner = "B"; m_pend = 0; m_wr = 0; m_num = 0; m_data = 0;
    reset = 1; a_valid = 0; b_valid = 0; issue_valid = 0;
    a_num = 0; b_num = 0; issue_num = 0; a_data = 0; b_data = 0;
    @(posedge clock); #1;

    // Reset state
    idle(1); idle(1);
    chk("rst_pending", pending, 32'h0);
    chk("rst_reg_write", reg_write, 1'b0);

    // Single A write to r3
    cycle(0, 1, 3, 32'h11, 0, 0, 0, 0, 0);
    chk("single_a_ready", obs_a, 1'b1);
    chk("single_num", num_write, 5'd3);
    chk("single_data", data_write, 32'h11);
    idle(0);
    chk("single_done", reg_write, 1'b0);
    chk("hold_num", num_write, 5'd3);

    // Contention from reset: A first, then alternate
    idle(1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 32'hA0 + i, 1, 2, 32'hB0 + i, 0, 0);
`ifdef GPR_WB_ARB_FIXED_PRIO_EN
      chk("contend_a", obs_a, 1'b1);
      chk("contend_b", obs_b, 1'b0);
`else
      chk("contend_a", obs_a, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("contend_b", obs_b, (i % 2 == 1) ? 1'b1 : 1'b0);
`endif
    end
    idle(0);

    // Issue r5, later B writes r5
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("issue5_set", pending[5], 1'b1);
    idle(0);
    cycle(0, 0, 0, 0, 1, 5, 32'h55, 0, 0);
    chk("issue5_still", pending[5], 1'b1);
    idle(0);
    chk("issue5_clear", pending[5], 1'b0);

    // Set wins over a same-cycle clear on r7; issue to r0 ignored
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cycle(0, 1, 7, 32'h77, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 7);
    chk("setwins_7", pending[7], 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("issue0_bit0", pending[0], 1'b0);

    // Write to r0 accepted but suppressed
    cycle(0, 1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
    chk("r0_ready", obs_a, 1'b1);
    chk("r0_no_write", reg_write, 1'b0);
    chk("r0_pending7", pending[7], 1'b1);

    // Transfer during reset is discarded; A wins the first contention afterwards
    cycle(0, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    cycle(1, 1, 4, 32'h44, 1, 6, 32'h66, 1, 8);
    chk("rstx_ready", {obs_a, obs_b}, 2'b00);
    chk("rstx_write", reg_write, 1'b0);
    chk("rstx_pending", pending, 32'h0);
    cycle(0, 1, 4, 32'h44, 1, 6, 32'h66, 0, 0);
    chk("rstx_a_first", obs_a, 1'b1);

    // Randomized traffic; an ungranted request is held unchanged
    hav = 0; hbv = 0; han = 0; hbn = 0; had = 0; hbd = 0;
    for (int i = 0; i < 500; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      if (!hav || ga) begin
        hav = ($urandom_range(0, 2) != 0);
        han = ADDR_W'($urandom_range(0, 7));
        had = $urandom;
      end
      if (!hbv || gb) begin
        hbv = ($urandom_range(0, 2) != 0);
        hbn = ADDR_W'($urandom_range(0, 31));
        hbd = $urandom;
      end
      hiv = ($urandom_range(0, 1) != 0);
      hin = ADDR_W'($urandom_range(0, 7));
      cycle(rr, hav, han, had, hbv, hbn, hbd, hiv, hin);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, as the write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, as the register-number width (32 registers).
REQ-003 The block SHALL have clock  input  1  as its single clock; all state updates on posedge clock.
REQ-004 The block SHALL have reset  input  1  as a synchronous, active-high reset.
REQ-005 The block SHALL have a_valid  input  1  as the requester A (ALU writeback) write request.
REQ-006 The block SHALL have a_num  input  ADDR_W  as the requester A destination register.
REQ-007 The block SHALL have a_data  input  DATA_W  as the requester A write data.
REQ-008 The block SHALL have a_ready  output  1  as the requester A grant; transfer occurs when a_valid&a_ready.
REQ-009 The block SHALL have b_valid, b_num, b_data, b_ready with the same widths and meanings as REQ-005..008, for requester B (load/multicycle unit).
REQ-010 The block SHALL have issue_valid  input  1  as a request to mark a register pending.
REQ-011 The block SHALL have issue_num  input  ADDR_W  as the register to mark pending.
REQ-012 The block SHALL have reg_write  output  1  as the register-file write enable.
REQ-013 The block SHALL have num_write  output  ADDR_W  as the register-file write number.
REQ-014 The block SHALL have data_write  output  DATA_W  as the register-file write data.
REQ-015 The block SHALL have pending  output  32  as the scoreboard; bit i set = write to register i outstanding.

Function
REQ-016 At most one request SHALL be granted per cycle; a_ready/b_ready are combinational from valids and the priority state, and never both 1.
REQ-017 A ready SHALL NOT be asserted unless its valid is asserted.
REQ-018 With one valid asserted, that requester SHALL be granted in the same cycle.
REQ-019 With both valid, the requester not granted most recently SHALL be granted (round-robin); the last-granted pointer SHALL update only on a transfer.
REQ-020 A transfer in cycle N SHALL produce reg_write=1 with the captured num/data in cycle N+1 (registered outputs, one-cycle latency); reg_write=0 in cycles following no transfer.
REQ-021 A transfer with num=0 SHALL be accepted but SHALL yield reg_write=0 in cycle N+1 and SHALL NOT change pending.
REQ-022 num_write/data_write SHALL hold their last values when reg_write=0.
REQ-023 issue_valid with issue_num≠0 SHALL set pending[issue_num] in cycle N+1; issue_num=0 SHALL be ignored.
REQ-024 A reg_write to register r SHALL clear pending[r] at the same clock edge the write occurs.
REQ-025 If a set and a clear target the same register in one cycle, the set SHALL win (pending stays 1).
REQ-026 pending[0] SHALL always read 0.
REQ-027 A requester holding valid without grant SHALL wait indefinitely; the block SHALL NOT drop or reorder a held request.

Reset
REQ-028 While reset=1 at a clock edge: reg_write=0, num_write=0, data_write=0, pending=0, last-granted pointer = B (so A wins the first contention).
REQ-029 A transfer handshake in a reset cycle SHALL be discarded (no write in the following cycle); a_ready/b_ready SHALL be 0 while reset=1.
REQ-030 An issue_valid in a reset cycle SHALL be ignored.

Configuration
REQ-031 Macro GPR_WB_ARB_FIXED_PRIO_EN: when defined, A SHALL always win contention (no round-robin pointer); when undefined, REQ-019 round-robin applies.

Verification
REQ-032 Reset, then a_valid=1 a_num=3 a_data=0x11 for one cycle -> a_ready=1 same cycle; next cycle reg_write=1 num_write=3 data_write=0x11.
REQ-033 Both valid for 4 cycles (A num=1, B num=2) -> grants A,B,A,B; writes appear one cycle later in that order; with GPR_WB_ARB_FIXED_PRIO_EN -> A,A,A,A and b_ready=0.
REQ-034 issue_valid num=5, later B write num=5 -> pending[5]=1 from the issue edge until the write edge, then 0.
REQ-035 Same cycle issue num=7 and reg_write num=7 -> pending[7] remains 1; issue num=0 -> pending=0.
REQ-036 A write num=0 data=0xFFFF -> a_ready=1, next cycle reg_write=0, pending unchanged.
REQ-037 Transfer and reset asserted in same cycle -> next cycle reg_write=0, pending=0; subsequent contention grants A first.
